// File: rtl/fp_inv_sqrt_folded_pkg.sv
// Shared constants for the folded Q16.16 inverse-square-root unit.
// Holds the Q16.16/Q2.30 formats, FSM state codes and the initial-guess LUT.
// No ports; imported by fp_inv_sqrt_folded and fp_mul_q230.
package fp_inv_sqrt_folded_pkg;

   localparam int WIDTH     = 32;   // operand/result width, Q16.16
   localparam int FRAC_BITS = 16;   // fractional bits of operand and result
   localparam int NR_ITERS  = 3;    // Newton-Raphson iterations
   localparam int LUT_BITS  = 4;    // fraction bits of m used to index the seed LUT
   localparam int Q_FRAC    = 30;   // internal fixed point is unsigned Q2.30
   localparam int SEED_BITS = 8;    // precision of each stored seed, value = L/256

   localparam logic [WIDTH-1:0] FP_MAX     = 32'h7FFF_FFFF;
   localparam logic [WIDTH-1:0] Q230_ONE   = 32'h4000_0000;
   localparam logic [WIDTH-1:0] Q230_THREE = 32'hC000_0000;

   // Output shift is 14+k with k = (msb_pos/2) - 8, so the base is 14-8.
   localparam logic [4:0] SH_BASE = 5'(Q_FRAC - FRAC_BITS - 8);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_NORM   = 3'd1;
   localparam logic [2:0] S_SEED   = 3'd2;
   localparam logic [2:0] S_SQ     = 3'd3;
   localparam logic [2:0] S_MX     = 3'd4;
   localparam logic [2:0] S_UPD    = 3'd5;
   localparam logic [2:0] S_DENORM = 3'd6;

   // Normaliser result: mantissa m in [1,4) as Q2.30, output shift 14+k,
   // and a flag for operands with no real inverse square root.
   typedef struct packed {
      logic             bad;
      logic [4:0]       sh;
      logic [WIDTH-1:0] m;
   } norm_t;

   // 1/sqrt at the midpoint of each 1/16-wide slot of m, scaled by 256.
   // Rows: integer part of m = 1, 2, 3.
   localparam logic [SEED_BITS-1:0] SEED_LUT [48] = '{
      8'd252, 8'd245, 8'd238, 8'd232, 8'd226, 8'd221, 8'd216, 8'd211,
      8'd207, 8'd203, 8'd199, 8'd195, 8'd192, 8'd189, 8'd185, 8'd182,
      8'd180, 8'd177, 8'd174, 8'd172, 8'd169, 8'd167, 8'd165, 8'd163,
      8'd161, 8'd159, 8'd157, 8'd155, 8'd154, 8'd152, 8'd150, 8'd149,
      8'd147, 8'd146, 8'd144, 8'd143, 8'd141, 8'd140, 8'd139, 8'd137,
      8'd136, 8'd135, 8'd134, 8'd133, 8'd132, 8'd131, 8'd130, 8'd129
   };

   // top = integer bits of m followed by its LUT_BITS leading fraction bits.
   function automatic logic [WIDTH-1:0] seed_q230(input logic [LUT_BITS+1:0] top);
      logic [5:0] idx;
      idx = {top[LUT_BITS+1:LUT_BITS] - 2'd1, top[LUT_BITS-1:0]};
      if (idx > 6'd47)
         idx = 6'd0;   // integer part 0 cannot occur for a normalised m
      return {2'b00, SEED_LUT[idx], {(Q_FRAC - SEED_BITS){1'b0}}};
   endfunction

endpackage

// File: rtl/fp_mul_q230.sv
// Registered 32x32 unsigned multiply returning (a*b)>>30, i.e. a Q2.30 product.
// Latency 1 cycle; no handshake, the caller schedules operands every cycle.
// Ports: i_clk clock, i_a/i_b Q2.30 operands, o_p registered Q2.30 product.
module fp_mul_q230
   import fp_inv_sqrt_folded_pkg::*;
(
   input  logic             i_clk,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   output logic [WIDTH-1:0] o_p
);

   // Products stay below 4.0 in this datapath, so the truncation is lossless
   // at the top and simply drops the low 30 bits.
   always_ff @(posedge i_clk) begin
      o_p <= WIDTH'((64'(i_a) * 64'(i_b)) >> Q_FRAC);
   end

endmodule

// File: rtl/fp_inv_sqrt_folded.sv
// Folded 1/sqrt(a) for signed Q16.16: normalise, LUT seed, 3 Newton-Raphson steps.
// Latency 12 cycles from accept edge to valid_out; one shared registered multiplier.
// Backpressure: ready_out high only in IDLE; valid_in ignored while busy.
// Ports: clk_in, rst_in (sync, active-high), a_in/valid_in/ready_out operand
//        handshake, res_out (held) with valid_out one-cycle update pulse.
module fp_inv_sqrt_folded
   import fp_inv_sqrt_folded_pkg::*;
(
   input  logic             clk_in,
   input  logic             rst_in,
   input  logic [WIDTH-1:0] a_in,
   input  logic             valid_in,
   output logic [WIDTH-1:0] res_out,
   output logic             valid_out,
   output logic             ready_out
);

   logic [2:0]       r_state;
   logic [1:0]       r_iter;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_m;
   logic [WIDTH-1:0] r_y;
   logic [4:0]       r_sh;
   logic             r_bad;

   logic [3:0]       w_pair;
   norm_t            w_norm;
   logic [WIDTH-1:0] w_mul_a;
   logic [WIDTH-1:0] w_mul_b;
   logic [WIDTH-1:0] w_mul_p;
   logic [WIDTH-1:0] w_y_cur;
   logic [WIDTH-1:0] w_h;
   logic [WIDTH:0]   w_rnd_sum;

   assign ready_out = (r_state == S_IDLE);

   // Even-shift normaliser: with the MSB at bit p, shifting left by
   // 30 - 2*floor(p/2) lands the MSB on bit 30 or 31, i.e. m in [1,4).
   always_comb begin
      w_pair = '0;
      for (int i = 0; i < WIDTH - 1; i++) begin
         if (r_a[i])
            w_pair = 4'(i / 2);
      end
      w_norm.bad = r_a[WIDTH-1] | (r_a == '0);
      w_norm.sh  = SH_BASE + {1'b0, w_pair};
      w_norm.m   = r_a << (5'd30 - {w_pair, 1'b0});
      if (w_norm.bad)
         w_norm.m = Q230_ONE;   // keeps the seed index legal; result is overridden
   end

   // The product of UPD is the new y; the first SQ takes the seed instead.
   assign w_y_cur = (r_iter == 2'd0) ? r_y : w_mul_p;
   assign w_h     = (Q230_THREE - w_mul_p) >> 1;

   always_comb begin
      w_mul_a = r_y;
      w_mul_b = r_y;
      case (r_state)
         S_SQ: begin
            w_mul_a = w_y_cur;
            w_mul_b = w_y_cur;
         end
         S_MX: begin
            w_mul_a = r_m;
            w_mul_b = w_mul_p;    // t = y*y
         end
         S_UPD: begin
            w_mul_a = r_y;
            w_mul_b = w_h;        // h from u = m*t
         end
         default: ;
      endcase
   end

   // Round half up before dropping 14+k bits.
   assign w_rnd_sum = {1'b0, w_mul_p} + ((WIDTH+1)'(1) << (r_sh - 5'd1));

   fp_mul_q230 u_mul (
      .i_clk (clk_in),
      .i_a   (w_mul_a),
      .i_b   (w_mul_b),
      .o_p   (w_mul_p)
   );

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_state   <= S_IDLE;
         r_iter    <= '0;
         r_a       <= '0;
         r_m       <= '0;
         r_y       <= '0;
         r_sh      <= '0;
         r_bad     <= 1'b0;
         res_out   <= '0;
         valid_out <= 1'b0;
      end else begin
         valid_out <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (valid_in) begin
                  r_a     <= a_in;
                  r_state <= S_NORM;
               end
            end
            S_NORM: begin
               r_m     <= w_norm.m;
               r_sh    <= w_norm.sh;
               r_bad   <= w_norm.bad;
               r_state <= S_SEED;
            end
            S_SEED: begin
               r_y     <= seed_q230(r_m[WIDTH-1:Q_FRAC-LUT_BITS]);
               r_iter  <= '0;
               r_state <= S_SQ;
            end
            S_SQ: begin
               r_y     <= w_y_cur;
               r_state <= S_MX;
            end
            S_MX: begin
               r_state <= S_UPD;
            end
            S_UPD: begin
               if (r_iter == 2'(NR_ITERS - 1)) begin
                  r_state <= S_DENORM;
               end else begin
                  r_iter  <= r_iter + 2'd1;
                  r_state <= S_SQ;
               end
            end
            S_DENORM: begin
               res_out   <= r_bad ? FP_MAX : WIDTH'(w_rnd_sum >> r_sh);
               valid_out <= 1'b1;
               r_state   <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fp_inv_sqrt_folded.sv
// Directed testbench for fp_inv_sqrt_folded: vector table plus handshake/reset sequences.
// Latency expectation 12 cycles from accept edge to valid_out.
// Drives valid_in for one cycle per operand except in the hold-while-busy sequence.
module tb_fp_inv_sqrt_folded;

   logic        clk_in = 1'b0;
   logic        rst_in;
   logic [31:0] a_in;
   logic        valid_in;
   logic [31:0] res_out;
   logic        valid_out;
   logic        ready_out;

   int checks   = 0;
   int failures = 0;

   localparam int          LAT    = 12;
   localparam logic [31:0] FP_MAX = 32'h7FFF_FFFF;

   typedef struct {
      logic [31:0] a;
      logic [31:0] exp;
      int          tol;
   } vec_t;

   vec_t vecs [17];

   always #5 clk_in = ~clk_in;

   fp_inv_sqrt_folded dut (
      .clk_in    (clk_in),
      .rst_in    (rst_in),
      .a_in      (a_in),
      .valid_in  (valid_in),
      .res_out   (res_out),
      .valid_out (valid_out),
      .ready_out (ready_out)
   );

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp, input int tol);
      longint d;
      d = longint'(act) - longint'(exp);
      if (d < 0)
         d = -d;
      checks++;
      if (d > longint'(tol)) begin
         failures++;
         $display("FAIL %s: got 0x%08h required 0x%08h (tol %0d)", name, act, exp, tol);
      end
   endtask

   // One-cycle valid_in pulse; returns result, edges to valid_out,
   // cycles ready_out was seen low, and ready_out on the valid_out cycle.
   task automatic run_op(input logic [31:0] a, output logic [31:0] res,
                         output int lat, output int rdy_low, output logic rdy_at_vld);
      int guard;
      guard = 0;
      @(negedge clk_in);
      while (!ready_out && guard < 100) begin
         @(negedge clk_in);
         guard++;
      end
      a_in     = a;
      valid_in = 1'b1;
      @(posedge clk_in);
      #1;
      valid_in = 1'b0;
      lat      = 0;
      rdy_low  = 0;
      while (!valid_out && lat < 40) begin
         if (!ready_out)
            rdy_low++;
         @(posedge clk_in);
         #1;
         lat++;
      end
      res        = res_out;
      rdy_at_vld = ready_out;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] res;
      int          lat;
      int          rdy_low;
      logic        rdy_v;
      int          n_vld;

      // Sweep, exact points, range extremes, invalid operands.
      vecs[0]  = '{32'd32768,     32'd92682,    6};  // 0.5
      vecs[1]  = '{32'd39322,     32'd84607,    6};  // 0.6
      vecs[2]  = '{32'd45875,     32'd78331,    6};  // 0.7
      vecs[3]  = '{32'd52429,     32'd73271,    6};  // 0.8
      vecs[4]  = '{32'd58982,     32'd69081,    6};  // 0.9
      vecs[5]  = '{32'd65536,     32'd65536,    6};  // 1.0
      vecs[6]  = '{32'd242483,    32'd34071,    6};  // 3.7
      vecs[7]  = '{32'd380109,    32'd27212,    6};  // 5.8
      vecs[8]  = '{32'd98304,     32'd53510,    6};  // 1.5
      vecs[9]  = '{32'd452198,    32'd24949,    6};  // 6.9
      vecs[10] = '{32'h0001_0000, 32'h0001_0000, 0};
      vecs[11] = '{32'h0004_0000, 32'h0000_8000, 0};
      vecs[12] = '{32'h0000_8000, 32'h0001_6A0A, 6};
      vecs[13] = '{32'h0000_0001, 32'h0100_0000, 0};
      vecs[14] = '{32'h7FFF_FFFF, 32'd362,      6};
      vecs[15] = '{32'h0000_0000, FP_MAX,       0};
      vecs[16] = '{32'hFFFF_0000, FP_MAX,       0};

      rst_in   = 1'b1;
      valid_in = 1'b0;
      a_in     = '0;
      repeat (3) @(posedge clk_in);
      #1;
      chk("reset_res_out",   res_out,            32'd0, 0);
      chk("reset_valid_out", {31'd0, valid_out}, 32'd0, 0);
      chk("reset_ready_out", {31'd0, ready_out}, 32'd1, 0);
      @(negedge clk_in);
      rst_in = 1'b0;

      for (int i = 0; i < 17; i++) begin
         run_op(vecs[i].a, res, lat, rdy_low, rdy_v);
         chk($sformatf("vec%0d_result", i),     res,              vecs[i].exp, vecs[i].tol);
         chk($sformatf("vec%0d_latency", i),    32'(lat),         32'(LAT),    0);
         chk($sformatf("vec%0d_ready_low", i),  32'(rdy_low),     32'(LAT),    0);
         chk($sformatf("vec%0d_ready_at_vld", i), {31'd0, rdy_v}, 32'd1,       0);
      end

      // valid_in held high while busy, with a different operand presented:
      // only the first operand (4.0) is computed, and only once.
      @(negedge clk_in);
      a_in     = 32'h0004_0000;
      valid_in = 1'b1;
      @(posedge clk_in);
      #1;
      a_in = 32'h0001_0000;
      lat  = 0;
      while (!valid_out && lat < 40) begin
         @(posedge clk_in);
         #1;
         lat++;
      end
      n_vld    = valid_out ? 1 : 0;
      res      = res_out;
      valid_in = 1'b0;
      repeat (20) begin
         @(posedge clk_in);
         #1;
         if (valid_out)
            n_vld++;
      end
      chk("hold_result",    res,        32'h0000_8000, 0);
      chk("hold_latency",   32'(lat),   32'(LAT),      0);
      chk("hold_one_valid", 32'(n_vld), 32'd1,         0);

      // Reset during the fifth busy cycle aborts the operation.
      @(negedge clk_in);
      a_in     = 32'h0001_0000;
      valid_in = 1'b1;
      @(posedge clk_in);
      #1;
      valid_in = 1'b0;
      repeat (4) begin
         @(posedge clk_in);
         #1;
      end
      chk("rst_busy_before", {31'd0, ready_out}, 32'd0, 0);
      @(negedge clk_in);
      rst_in = 1'b1;
      @(posedge clk_in);
      #1;
      chk("rst_ready_out", {31'd0, ready_out}, 32'd1, 0);
      chk("rst_res_out",   res_out,            32'd0, 0);
      chk("rst_valid_out", {31'd0, valid_out}, 32'd0, 0);
      @(negedge clk_in);
      rst_in = 1'b0;
      n_vld  = 0;
      repeat (20) begin
         @(posedge clk_in);
         #1;
         if (valid_out)
            n_vld++;
      end
      chk("rst_no_valid", 32'(n_vld), 32'd0, 0);

      // Unit works normally after the abort.
      run_op(32'h0004_0000, res, lat, rdy_low, rdy_v);
      chk("post_rst_result",  res,      32'h0000_8000, 0);
      chk("post_rst_latency", 32'(lat), 32'(LAT),      0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
